distri_ram_reader: RTL and testbench

Sequential read engine for the 16-entry distributed RAM used in the Aquila core. On a single-cycle start command it walks a contiguous, wrap-around address range of the RAM. It drives the RAM's asynchronous read address and registers each returned word into a valid/ready output stream. It sits beside the RAM's write port, is the consumer of what the write side stores, and supports full-throughput, back-pressured dumps such as buffer drain and debug readout.

---
 rtl/distri_ram_reader_pkg.sv | 13 +
 rtl/distri_ram.sv | 28 ++
 rtl/distri_ram_reader.sv | 92 +++++++++
 tb/tb_distri_ram_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/distri_ram_reader_pkg.sv
// Constants shared by the Aquila distributed RAM and its sequential reader.
// Both sides must agree on the depth and on the reader state encoding.
package distri_ram_reader_pkg;

    localparam int DISTRI_RAM_ENTRIES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/distri_ram.sv
// 16-entry distributed RAM: synchronous write, asynchronous read.
// A write to the address being read is visible only after the clock edge.
module distri_ram
    import distri_ram_reader_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int ENTRY_NUM = DISTRI_RAM_ENTRIES,
    localparam int AWDTH     = $clog2(ENTRY_NUM)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AWDTH-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [AWDTH-1:0] raddr_i,
    output logic [XLEN-1:0]  rdata_o
);

    logic [XLEN-1:0] r_mem [ENTRY_NUM];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/distri_ram_reader.sv
// Sequential read engine: walks a wrap-around RAM address range and
// streams each word out through a registered valid/ready port.
module distri_ram_reader
    import distri_ram_reader_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int ENTRY_NUM = DISTRI_RAM_ENTRIES,
    localparam int AWDTH     = $clog2(ENTRY_NUM)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [AWDTH-1:0] base_addr_i,
    input  logic [AWDTH-1:0] len_i,
    output logic [AWDTH-1:0] ram_addr_o,
    input  logic [XLEN-1:0]  ram_data_i,
    output logic [XLEN-1:0]  data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    rd_state_e        r_state;
    logic [AWDTH-1:0] r_addr;
    logic [AWDTH-1:0] r_rem;
    logic [XLEN-1:0]  r_data;
    logic             r_valid;
    logic             r_last;
    logic             r_done;

    logic w_hs;
    logic w_cap;

    assign w_hs  = r_valid && ready_i;
    assign w_cap = !r_valid || ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_addr  <= base_addr_i;
                        r_rem   <= len_i;
                        r_state <= READ;
                    end
                end
                READ: begin
                    // Power-of-two depth: the increment wraps on its own.
                    if (w_cap) begin
                        r_data  <= ram_data_i;
                        r_valid <= 1'b1;
                        r_addr  <= r_addr + AWDTH'(1);
                        if (r_rem == '0) begin
                            r_last  <= 1'b1;
                            r_state <= DRAIN;
                        end else begin
                            r_rem <= r_rem - AWDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_addr_o = r_addr;
    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign last_o     = r_last;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = r_done;

endmodule

// File: tb/tb_distri_ram_reader.sv
// Directed bench for distri_ram_reader driving a real distri_ram,
// with a scoreboard of expected words pushed at each accepted start.
module tb_distri_ram_reader;
    import distri_ram_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  base;
    logic [3:0]  len;
    logic [3:0]  ram_addr;
    logic [31:0] ram_data;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        last;
    logic        busy;
    logic        done;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic [31:0] model [16];
    exp_t        sbq [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    logic        stall_v = 1'b0;
    logic [31:0] stall_d;
    logic        stall_l;

    always #5 clk = ~clk;

    distri_ram u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (ram_addr),
        .rdata_o (ram_data)
    );

    distri_ram_reader u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .base_addr_i (base),
        .len_i       (len),
        .ram_addr_o  (ram_addr),
        .ram_data_i  (ram_data),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .last_o      (last),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, score any handshake, advance to edge+1.
    task automatic cyc(input logic rdy, input logic st,
                       input logic [3:0] b, input logic [3:0] l);
        exp_t e;
        ready = rdy;
        start = st;
        base  = b;
        len   = l;
        if (stall_v) begin
            check("stall_valid", valid, 1);
            check("stall_data", data, stall_d);
            check("stall_last", last, stall_l);
        end
        if (valid && rdy) begin
            if (sbq.size() == 0) begin
                check("extra_word", valid, 0);
            end else begin
                e = sbq.pop_front();
                check("data", data, e.d);
                check("last", last, e.l);
            end
        end
        stall_v = valid && !rdy;
        stall_d = data;
        stall_l = last;
        if (st && !busy) begin
            for (int i = 0; i <= int'(l); i++) begin
                e.d = model[4'(int'(b) + i)];
                e.l = (i == int'(l));
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (we) begin
            model[waddr] = wdata;
            we = 1'b0;
        end
        if (done) n_done++;
    endtask

    task automatic run_idle(input int maxc, input bit rnd, input bit st);
        int c = 0;
        while (busy && c < maxc) begin
            cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, st, 4'd0, 4'd0);
            c++;
        end
        check("timeout_busy", busy, 0);
        check("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        for (int i = 0; i < 16; i++) begin
            we    = 1'b1;
            waddr = 4'(i);
            wdata = 32'h1000 + 32'(i);
            @(posedge clk);
            #1;
            model[i] = 32'h1000 + 32'(i);
        end
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst with exact cycle timing
        cyc(1, 1, 4'd4, 4'd3);
        check("c1_busy", busy, 1);
        check("c1_addr", ram_addr, 4);
        check("c1_valid", valid, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", valid, 1);
            cyc(1, 0, 0, 0);
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", valid, 0);
        check("sb_basic", sbq.size(), 0);

        // Wrap-around, then back-to-back single-word start in N+1
        cyc(1, 1, 4'd14, 4'd3);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        check("wrap_done", done, 1);
        check("wrap_addr", ram_addr, 2);
        cyc(1, 1, 4'd9, 4'd0);
        cyc(1, 0, 0, 0);
        check("b2b_valid", valid, 1);
        check("single_last", last, 1);
        run_idle(10, 0, 0);

        // Back-pressure over a full 16-word dump
        d0 = n_done;
        cyc(0, 1, 4'd0, 4'd15);
        run_idle(400, 1, 0);
        check("bp_done_once", n_done - d0, 1);

        // Start pulsed during READ/DRAIN must be ignored
        d0 = n_done;
        cyc(1, 1, 4'd8, 4'd3);
        run_idle(20, 0, 1);
        cyc(1, 0, 0, 0);
        check("ign_done_once", n_done - d0, 1);
        check("ign_addr", ram_addr, 12);

        // Write collides with capture of address 5
        cyc(1, 1, 4'd5, 4'd0);
        we    = 1'b1;
        waddr = 4'd5;
        wdata = 32'hDEAD;
        cyc(1, 0, 0, 0);
        check("coll_old", data, 32'h1005);
        run_idle(10, 0, 0);
        cyc(1, 1, 4'd5, 4'd0);
        run_idle(10, 0, 0);

        // Asynchronous reset after 3 handshakes of a 16-word read
        d0 = n_done;
        cyc(1, 1, 4'd0, 4'd15);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", valid, 0);
        check("mid_data", data, 0);
        check("mid_last", last, 0);
        check("mid_busy", busy, 0);
        check("mid_addr", ram_addr, 0);
        sbq.delete();
        stall_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_nodone", done, 0);
        cyc(1, 0, 0, 0);
        check("mid_ndone", n_done - d0, 0);
        cyc(1, 1, 4'd2, 4'd1);
        run_idle(10, 0, 0);
        check("post_rst_done", n_done - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
